// File: rtl/bcd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : bcd_pkg                                            |
// | Description : Shared constants and state encoding for the        |
// |               sequential double-dabble binary-to-BCD converter.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam logic [3:0]  BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0]  BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : bcd_digit_adj                                      |
// | Description : Double-dabble per-digit correction: adds 3 to a    |
// |               BCD digit that is 5 or more, before the shift.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Digits 5..9 become 8..12 so the following shift carries into the next digit.
    always_comb begin
        dout = (din >= BCD_ADJ_THRESH) ? (din + BCD_ADJ_ADD) : din;
    end

endmodule
`default_nettype wire

// File: rtl/bcd_converter_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : bcd_converter_seq                                  |
// | Description : Iterative double-dabble converter, one shift/adjust|
// |               step per clock, start/done handshake. Optional     |
// |               leading-zero blank mask enabled by the macro       |
// |               BCD_LEADING_ZERO_BLANK_EN.                         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module bcd_converter_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [WIDTH-1:0]                bin,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]               blank
);

    localparam int unsigned       c_SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned       c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_shift;
    logic [c_SCR_W-1:0]     r_scratch;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [c_SCR_W-1:0]     r_bcd;

    logic [c_SCR_W-1:0]         w_adj;
    logic [c_SCR_W+WIDTH-1:0]   w_shifted;
    logic [c_SCR_W-1:0]         w_next_scr;
    logic [WIDTH-1:0]           w_next_shift;
    logic                       w_last;

    // One add-3 corrector per scratch digit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .din  (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dout (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Adjusted scratch and remaining binary bits shift left together as one register.
    always_comb begin
        w_shifted    = {w_adj, r_shift} << 1;
        w_next_scr   = w_shifted[c_SCR_W+WIDTH-1:WIDTH];
        w_next_shift = w_shifted[WIDTH-1:0];
        w_last       = (r_state == S_SHIFT) && (r_cnt == c_LAST);
    end

    // Control FSM with registered busy/done and result register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_next_scr;
                    r_shift   <= w_next_shift;
                    r_cnt     <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Publish the final scratch directly so bcd never shows a partial value.
                        r_bcd   <= w_next_scr;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_next;

    // Walk from the top digit down; a digit blanks only while everything above it is zero.
    always_comb begin
        logic v_zero_above;
        v_zero_above = 1'b1;
        w_blank_next = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            v_zero_above    = v_zero_above && (w_next_scr[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            w_blank_next[i] = v_zero_above;
        end
    end

    // Blank mask tracks bcd: updated on the same edge, cleared by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_blank <= '0;
        end else if (w_last) begin
            r_blank <= w_blank_next;
        end
    end

    assign blank = r_blank;
`else
    assign blank = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_converter_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_bcd_converter_seq                               |
// | Description : Self-checking bench for bcd_converter_seq: directed|
// |               vector table, multi-cycle corner sequences and a   |
// |               random sweep against a decimal reference model.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_bcd_converter_seq;

    localparam int WIDTH   = 16;
    localparam int DIGITS  = 5;
    localparam int LATENCY = WIDTH + 1;

    logic                  clk;
    logic                  resetn;
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    int checks;
    int passed;

    bcd_converter_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .blank  (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] b;
        int          poke;
        logic [19:0] exp_bcd;
        logic [4:0]  exp_blank;
    } vec_t;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Decimal digits computed by repeated division.
    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digit i (i>=1) is a leading zero exactly when the value is below 10^i.
    function automatic logic [4:0] ref_blank(input int v);
        logic [4:0] m;
        int         p;
        m = '0;
        p = 1;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            p = p * 10;
            m[i] = (v < p);
        end
`else
        p = v;
`endif
        return m;
    endfunction

    // One conversion: start in cycle 0, optional re-start poke during SHIFT,
    // checks latency, busy window, result, and one-cycle done.
    task automatic run_conv(input logic [15:0] b, input int poke,
                            input logic [19:0] exp_bcd, input logic [4:0] exp_blank);
        int n;
        bit busy_ok;
        bin   = b;
        start = 1'b1;
        step();
        start = 1'b0;
        bin   = 16'($urandom);
        n       = 1;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (n == poke) begin
                start = 1'b1;
                bin   = 16'd9999;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        chk("latency", n, LATENCY);
        chk("busy_window", 32'(busy_ok), 1);
        chk("bcd", 32'(bcd), 32'(exp_bcd));
        chk("blank", 32'(blank), 32'(exp_blank));
        chk("busy_at_done", 32'(busy), 0);
        step();
        chk("done_width", 32'(done), 0);
        chk("busy_after", 32'(busy), 0);
    endtask

    initial begin
        vec_t vecs[10];
        int   n;
        bit   no_done;
        int   r;

        checks = 0;
        passed = 0;
        resetn = 1'b0;
        start  = 1'b0;
        bin    = '0;

        vecs[0] = '{16'd0,     -1, 20'h00000, 5'b11110};
        vecs[1] = '{16'd65535, -1, 20'h65535, 5'b00000};
        vecs[2] = '{16'd65025, -1, 20'h65025, 5'b00000};
        vecs[3] = '{16'd1234,   5, 20'h01234, 5'b10000};
        vecs[4] = '{16'd42,    -1, 20'h00042, 5'b11100};
        vecs[5] = '{16'd7,     -1, 20'h00007, 5'b11110};
        vecs[6] = '{16'd500,   -1, 20'h00500, 5'b11000};
        vecs[7] = '{16'd9,     -1, 20'h00009, 5'b11110};
        vecs[8] = '{16'd10,    -1, 20'h00010, 5'b11100};
        vecs[9] = '{16'd59999, -1, 20'h59999, 5'b00000};
`ifndef BCD_LEADING_ZERO_BLANK_EN
        for (int i = 0; i < 10; i++) vecs[i].exp_blank = '0;
`endif

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_blank", 32'(blank), 0);
        resetn = 1'b1;
        step();

        // Directed table (entry 3 pokes start with bin=9999 at cycle 5)
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].b, vecs[i].poke, vecs[i].exp_bcd, vecs[i].exp_blank);
        end

        // Back-to-back: start held high, second operand presented in the DONE cycle
        bin   = 16'd42;
        start = 1'b1;
        step();
        n = 1;
        while (!done && n < 40) begin step(); n++; end
        chk("b2b_lat1", n, LATENCY);
        chk("b2b_bcd1", 32'(bcd), 32'h00042);
        bin = 16'd7;
        step();
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin step(); n++; end
        chk("b2b_lat2", n, LATENCY);
        chk("b2b_bcd2", 32'(bcd), 32'h00007);
        step();
        chk("b2b_done_width", 32'(done), 0);

        // Reset at cycle 8 of a conversion of 500 aborts without a done pulse
        bin   = 16'd500;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 8; c++) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_bcd", 32'(bcd), 0);
        chk("abort_blank", 32'(blank), 0);
        no_done = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (done || busy) no_done = 1'b0;
            step();
        end
        chk("abort_idle", 32'(no_done), 1);
        run_conv(16'd500, -1, 20'h00500, ref_blank(500));

        // Random sweep against the decimal model
        for (int k = 0; k < 1000; k++) begin
            r = int'($urandom_range(0, 65535));
            run_conv(16'(r), -1, ref_bcd(r), ref_blank(r));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
